uart_rx_shift_ctrl: RTL and testbench
=====================================

// Module: uart_rx_shift_ctrl
// PURPOSE
//  Receive sequencer for the UART serial-in path. Detects the start bit and samples each bit
//  at mid-period with a baud counter. For every sample it drives enable/d of an external
//  DATA_WIDTH right-shift register, which fills LSB-first. It then checks the stop bit and
//  reports frame status through a valid/ack handshake to the bus/CPU side.
// PARAMETERS
//  BAUD_DIV    434  clk cycles per serial bit (50 MHz / 115200); legal >= 4
//  DATA_WIDTH  8    data bits per frame; equals width of the driven shift register
//  CNT_W       $clog2(BAUD_DIV)  localparam, baud counter width
// PORTS
//  clk        in   1  system clock, all logic on rising edge
//  rst        in   1  synchronous, active-high reset
//  rx         in   1  asynchronous serial line, idle high
//  rx_ack     in   1  consumer acknowledges received word; clears rx_valid/overrun
//  sr_enable  out  1  shift enable to external shift register, one-cycle pulse per data bit
//  sr_d       out  1  sampled data bit to shift register, valid while sr_enable=1
//  rx_valid   out  1  word in shift register complete and unread (sticky)
//  overrun    out  1  a frame completed while rx_valid was still set (sticky)
//  frame_err  out  1  one-cycle pulse: stop bit sampled low
//  busy       out  1  high whenever state != IDLE
// BEHAVIOUR
//  - rx passes through a 2-FF synchronizer (rx_s); both flops reset to 1.
//  - Reset: state=IDLE, counter=0, bit_idx=0, all outputs 0. Reset mid-frame aborts the frame.
//    External shift register contents are not cleared.
//  - IDLE: when rx_s==0 -> START, counter=0.
//  - START: count to BAUD_DIV/2-1. At terminal: rx_s==0 -> DATA (counter=0, bit_idx=0);
//    rx_s==1 (glitch) -> IDLE, no shift.
//  - DATA: count to BAUD_DIV-1. At terminal: next cycle sr_enable=1 and sr_d=rx_s (both
//    registered), bit_idx++. After the DATA_WIDTH-th sample -> STOP, counter=0.
//  - STOP: count to BAUD_DIV-1. At terminal:
//      rx_s==1 -> IDLE; rx_valid=1 next cycle. If rx_valid already 1 and rx_ack=0, overrun=1.
//      rx_s==0 -> frame_err pulses 1 cycle -> BREAK; rx_valid unchanged.
//  - BREAK: wait for rx_s==1 -> IDLE (no retrigger on held-low line).
//  - rx_ack=1 clears rx_valid and overrun next cycle. Exception: ack in the same cycle a
//    frame completes leaves rx_valid=1 and overrun=0 (new word replaces the acked one).
//  - Bits sampled at 1.5, 2.5 .. bit periods after the start edge, +2 cycles synchronizer lag.
//    Counter never exceeds BAUD_DIV-1; bit_idx width $clog2(DATA_WIDTH+1).
//  - sr_enable is never asserted outside DATA-bit samples (exactly DATA_WIDTH per good frame).
// TESTING  (bench instantiates the shift register with this block; BAUD_DIV=8, DATA_WIDTH=8)
//  1. Frame 0xA5 (start, 1,0,1,0,0,1,0,1, stop=1) -> 8 sr_enable pulses 8 cycles apart;
//     Q=0xA5; rx_valid=1; frame_err=0; busy falls with rx_valid rising.
//  2. rx low 2 cycles then high -> START then back to IDLE; no sr_enable; rx_valid stays 0.
//  3. Frame 0x3C with stop bit 0, line held low 40 cycles -> one frame_err pulse; busy high
//     until rx returns 1; rx_valid 0.
//  4. Frames 0x11 then 0x22, no ack -> rx_valid=1, overrun=1, Q=0x22; rx_ack pulse -> both 0
//     next cycle.
//  5. rx_ack asserted in the exact cycle frame 0x7E completes while rx_valid=1
//     -> rx_valid stays 1, overrun 0.
//  6. rst for 1 cycle during DATA bit 4 -> all outputs 0 and busy 0 next cycle;
//     following 0xC3 frame received correctly.

Source files
------------

// File: rtl/uart_rx_shift_ctrl.sv
// UART receive sequencer: synchronises rx, finds the start bit, samples each bit at mid-period
// and drives an external LSB-first right-shift register, then reports frame status.
module uart_rx_shift_ctrl #(
    parameter int BAUD_DIV   = 434,
    parameter int DATA_WIDTH = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic rx,
    input  logic rx_ack,
    output logic sr_enable,
    output logic sr_d,
    output logic rx_valid,
    output logic overrun,
    output logic frame_err,
    output logic busy
);

    localparam int CNT_W = $clog2(BAUD_DIV);
    localparam int IDX_W = $clog2(DATA_WIDTH + 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(BAUD_DIV / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(BAUD_DIV - 1);
    localparam logic [IDX_W-1:0] LAST_BIT  = IDX_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [IDX_W-1:0] r_bit_idx;
    logic             r_rx_meta;
    logic             r_rx_s;
    logic             r_sr_enable;
    logic             r_sr_d;
    logic             r_rx_valid;
    logic             r_overrun;
    logic             r_frame_err;
    logic             r_busy;

    logic             w_half_done;
    logic             w_full_done;

    // Both flops reset high so a reset never looks like a start edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_s    <= r_rx_meta;
        end
    end

    assign w_half_done = (r_cnt == HALF_LAST);
    assign w_full_done = (r_cnt == FULL_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_bit_idx   <= '0;
            r_sr_enable <= 1'b0;
            r_sr_d      <= 1'b0;
            r_rx_valid  <= 1'b0;
            r_overrun   <= 1'b0;
            r_frame_err <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_sr_enable <= 1'b0;
            r_frame_err <= 1'b0;
            if (rx_ack) begin
                r_rx_valid <= 1'b0;
                r_overrun  <= 1'b0;
            end
            case (r_state)
                S_IDLE: begin
                    if (!r_rx_s) begin
                        r_state <= S_START;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                S_START: begin
                    if (w_half_done) begin
                        r_cnt <= '0;
                        if (!r_rx_s) begin
                            r_state   <= S_DATA;
                            r_bit_idx <= '0;
                        end else begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_DATA: begin
                    if (w_full_done) begin
                        r_cnt       <= '0;
                        r_sr_enable <= 1'b1;
                        r_sr_d      <= r_rx_s;
                        r_bit_idx   <= r_bit_idx + IDX_W'(1);
                        if (r_bit_idx == LAST_BIT) begin
                            r_state <= S_STOP;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_STOP: begin
                    if (w_full_done) begin
                        r_cnt <= '0;
                        if (r_rx_s) begin
                            r_state    <= S_IDLE;
                            r_busy     <= 1'b0;
                            r_rx_valid <= 1'b1;
                            // An ack landing on completion consumed the old word, not the new one.
                            r_overrun  <= rx_ack ? 1'b0 : (r_overrun | r_rx_valid);
                        end else begin
                            r_frame_err <= 1'b1;
                            r_state     <= S_BREAK;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_BREAK: begin
                    if (r_rx_s) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= '0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign sr_enable = r_sr_enable;
    assign sr_d      = r_sr_d;
    assign rx_valid  = r_rx_valid;
    assign overrun   = r_overrun;
    assign frame_err = r_frame_err;
    assign busy      = r_busy;

endmodule

// File: tb/tb_uart_rx_shift_ctrl.sv
// Bench for uart_rx_shift_ctrl with an external 8-bit right-shift register (BAUD_DIV=8).
module tb_uart_rx_shift_ctrl;

    logic clk = 1'b0;
    logic rst;
    logic rx;
    logic rx_ack;
    logic sr_enable;
    logic sr_d;
    logic rx_valid;
    logic overrun;
    logic frame_err;
    logic busy;
    logic [7:0] sr_q = 8'h00;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int last_pulse = 0;
    int pulses  = 0;
    int fe_cnt  = 0;
    logic sb[$];

    uart_rx_shift_ctrl #(.BAUD_DIV(8), .DATA_WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .rx_ack    (rx_ack),
        .sr_enable (sr_enable),
        .sr_d      (sr_d),
        .rx_valid  (rx_valid),
        .overrun   (overrun),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (sr_enable) sr_q <= {sr_d, sr_q[7:1]};
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard: each sr_enable pulse must carry the next expected data bit, 8 cycles apart.
    always @(negedge clk) begin
        if (sr_enable) begin
            if (sb.size() == 0) begin
                check("sr_enable_unexpected", 32'd1, 32'd0);
            end else begin
                check("sr_d", 32'(sr_d), 32'(sb.pop_front()));
            end
            if (pulses > 0) check("sr_spacing", 32'(cyc - last_pulse), 32'd8);
            last_pulse = cyc;
            pulses++;
        end
        if (frame_err) fe_cnt++;
    end

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic       pre_ack;
        logic       ack_done;
        logic       exp_valid;
        logic       exp_ovr;
        int         exp_fe;
    } vec_t;

    vec_t vecs[6];
    logic prev_valid = 1'b0;

    task automatic ack_pulse();
        @(posedge clk); #1 rx_ack = 1'b1;
        @(posedge clk); #1 rx_ack = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] data, input logic stop, input logic ack_done,
                              input logic pv);
        pulses = 0;
        for (int b = 0; b < 8; b++) sb.push_back(data[b]);
        @(posedge clk); #1 rx = 1'b0;
        repeat (8) @(posedge clk);
        for (int b = 0; b < 8; b++) begin
            #1 rx = data[b];
            repeat (8) @(posedge clk);
        end
        #1 rx = stop;
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk); #1;
            if (i == 6) begin
                if (ack_done) rx_ack = 1'b1;
                check("busy_before_stop", 32'(busy), 32'd1);
                if (stop) check("valid_before_stop", 32'(rx_valid), 32'(pv));
            end
            if (i == 7) begin
                rx_ack = 1'b0;
                if (stop) begin
                    check("busy_fall_at_done", 32'(busy), 32'd0);
                    check("valid_rise_at_done", 32'(rx_valid), 32'd1);
                end
            end
        end
        if (!stop) begin
            repeat (40) @(posedge clk);
            #1;
            check("busy_in_break", 32'(busy), 32'd1);
            rx = 1'b1;
            repeat (6) @(posedge clk);
            #1;
            check("busy_after_break", 32'(busy), 32'd0);
        end
    endtask

    initial begin
        int fe_before;
        vecs[0] = '{data: 8'hA5, stop: 1'b1, pre_ack: 1'b0, ack_done: 1'b0, exp_valid: 1'b1, exp_ovr: 1'b0, exp_fe: 0};
        vecs[1] = '{data: 8'h3C, stop: 1'b0, pre_ack: 1'b1, ack_done: 1'b0, exp_valid: 1'b0, exp_ovr: 1'b0, exp_fe: 1};
        vecs[2] = '{data: 8'h11, stop: 1'b1, pre_ack: 1'b0, ack_done: 1'b0, exp_valid: 1'b1, exp_ovr: 1'b0, exp_fe: 0};
        vecs[3] = '{data: 8'h22, stop: 1'b1, pre_ack: 1'b0, ack_done: 1'b0, exp_valid: 1'b1, exp_ovr: 1'b1, exp_fe: 0};
        vecs[4] = '{data: 8'h5A, stop: 1'b1, pre_ack: 1'b1, ack_done: 1'b0, exp_valid: 1'b1, exp_ovr: 1'b0, exp_fe: 0};
        vecs[5] = '{data: 8'h7E, stop: 1'b1, pre_ack: 1'b0, ack_done: 1'b1, exp_valid: 1'b1, exp_ovr: 1'b0, exp_fe: 0};

        rst = 1'b1; rx = 1'b1; rx_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_sr_enable", 32'(sr_enable), 32'd0);
        check("rst_sr_d", 32'(sr_d), 32'd0);
        check("rst_valid", 32'(rx_valid), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("rst_frame_err", 32'(frame_err), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        repeat (4) @(posedge clk);

        // Glitch: two-cycle low pulse enters START then falls back to IDLE.
        #1 rx = 1'b0;
        repeat (2) @(posedge clk);
        #1 rx = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("glitch_busy_start", 32'(busy), 32'd1);
        repeat (4) @(posedge clk);
        #1;
        check("glitch_busy_idle", 32'(busy), 32'd0);
        repeat (16) @(posedge clk);
        #1;
        check("glitch_valid", 32'(rx_valid), 32'd0);
        check("glitch_no_shift", 32'(pulses), 32'd0);

        for (int v = 0; v < 6; v++) begin
            if (vecs[v].pre_ack) begin
                ack_pulse();
                prev_valid = 1'b0;
            end
            fe_before = fe_cnt;
            send_frame(vecs[v].data, vecs[v].stop, vecs[v].ack_done, prev_valid);
            $display("[TB] frame %0d data=0x%0h stop=%0b -> q=0x%0h valid=%0b ovr=%0b fe=%0d",
                     v, vecs[v].data, vecs[v].stop, sr_q, rx_valid, overrun, fe_cnt - fe_before);
            check("pulse_count", 32'(pulses), 32'd8);
            check("shift_q", 32'(sr_q), 32'(vecs[v].data));
            check("rx_valid", 32'(rx_valid), 32'(vecs[v].exp_valid));
            check("overrun", 32'(overrun), 32'(vecs[v].exp_ovr));
            check("frame_err_pulses", 32'(fe_cnt - fe_before), 32'(vecs[v].exp_fe));
            check("sb_drained", 32'(sb.size()), 32'd0);
            prev_valid = vecs[v].exp_valid;

            if (v == 3) begin
                // Ack clears valid and overrun on the following edge, not combinationally.
                @(posedge clk); #1 rx_ack = 1'b1;
                check("ack_valid_hold", 32'(rx_valid), 32'd1);
                @(posedge clk); #1 rx_ack = 1'b0;
                check("ack_clears_valid", 32'(rx_valid), 32'd0);
                check("ack_clears_ovr", 32'(overrun), 32'd0);
                prev_valid = 1'b0;
            end
        end

        // Reset during data bit 4 of a frame whose remaining bits are 1.
        pulses = 0;
        for (int b = 0; b < 4; b++) sb.push_back(1'b0);
        @(posedge clk); #1 rx = 1'b0;
        repeat (8) @(posedge clk);
        for (int b = 0; b < 4; b++) begin
            #1 rx = 1'b0;
            repeat (8) @(posedge clk);
        end
        #1 rx = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("busy_in_data", 32'(busy), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_valid", 32'(rx_valid), 32'd0);
        check("midrst_overrun", 32'(overrun), 32'd0);
        check("midrst_sr_enable", 32'(sr_enable), 32'd0);
        check("midrst_frame_err", 32'(frame_err), 32'd0);
        repeat (40) @(posedge clk);
        #1;
        check("midrst_pulses", 32'(pulses), 32'd4);
        check("midrst_sb", 32'(sb.size()), 32'd0);
        check("midrst_idle", 32'(busy), 32'd0);
        $display("[TB] reset mid-frame: pulses=%0d busy=%0b valid=%0b", pulses, busy, rx_valid);

        fe_before = fe_cnt;
        send_frame(8'hC3, 1'b1, 1'b0, 1'b0);
        $display("[TB] frame after reset data=0xc3 -> q=0x%0h valid=%0b ovr=%0b", sr_q, rx_valid, overrun);
        check("post_rst_pulses", 32'(pulses), 32'd8);
        check("post_rst_q", 32'(sr_q), 32'hC3);
        check("post_rst_valid", 32'(rx_valid), 32'd1);
        check("post_rst_ovr", 32'(overrun), 32'd0);
        check("post_rst_fe", 32'(fe_cnt - fe_before), 32'd0);

        repeat (4) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
